and_2: RTL and testbench

AND_2 -- requirements
Module: and_2

---
 rtl/and_2.sv | 29 ++
 tb/tb_and_2.sv | 122 ++++++++++++
 2 files changed

// File: rtl/and_2.sv
// and_2: two-input AND with registered copy, rising-edge pulse and saturating high-cycle counter
module and_2 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    output logic             c,
    output logic             c_q,
    output logic             c_rise,
    output logic [CNT_W-1:0] hi_cnt,
    output logic             hi_sat
);
    assign c      = a & b;
    assign hi_sat = &hi_cnt;
    // register c, flag its 0->1 edge and count high cycles up to the all-ones ceiling
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q    <= 1'b0;
            c_rise <= 1'b0;
            hi_cnt <= '0;
        end else begin
            c_q    <= c;
            c_rise <= c & ~c_q;
            if (c && !hi_sat) hi_cnt <= hi_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_and_2.sv
// tb_and_2: scoreboard bench for and_2 at CNT_W = 16 and CNT_W = 2
module tb_and_2;
    typedef struct {
        logic        cq;
        logic        cr;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        logic        sat2;
    } exp_t;

    logic        clk = 1'b0, clk_en = 1'b0;
    logic        rst = 1'b1, a = 1'b0, b = 1'b0;
    logic        c, c_q, c_rise, hi_sat;
    logic [15:0] hi_cnt;
    logic        c2, c_q2, c_rise2, hi_sat2;
    logic [1:0]  hi_cnt2;
    exp_t        q[$];
    int          tests = 0, fails = 0, pulses = 0;
    logic        count_pulses = 1'b0;

    and_2 #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .c_q(c_q),
                             .c_rise(c_rise), .hi_cnt(hi_cnt), .hi_sat(hi_sat));
    and_2 #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c2), .c_q(c_q2),
                             .c_rise(c_rise2), .hi_cnt(hi_cnt2), .hi_sat(hi_sat2));

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic av, input logic bv, input logic cq, input logic cr,
                        input int cnt, input int cnt2, input logic sat2);
        exp_t e;
        @(negedge clk);
        rst = r;
        a = av;
        b = bv;
        e.cq = cq;
        e.cr = cr;
        e.cnt = 16'(cnt);
        e.cnt2 = 2'(cnt2);
        e.sat2 = sat2;
        q.push_back(e);
        #1;
        chk("c_comb", int'(c), int'(av & bv));
        chk("c_comb_w2", int'(c2), int'(av & bv));
    endtask

    always @(posedge clk) begin
        #2;
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("c_q", int'(c_q), int'(e.cq));
            chk("c_rise", int'(c_rise), int'(e.cr));
            chk("hi_cnt", int'(hi_cnt), int'(e.cnt));
            chk("hi_sat", int'(hi_sat), 0);
            chk("c_q_w2", int'(c_q2), int'(e.cq));
            chk("hi_cnt_w2", int'(hi_cnt2), int'(e.cnt2));
            chk("hi_sat_w2", int'(hi_sat2), int'(e.sat2));
            if (count_pulses && c_rise) pulses++;
        end
    end

    initial begin
        logic [1:0] ab;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            {a, b} = ab;
            #50;
            chk("tt_mid", int'(c), int'(ab == 2'b11));
            #49;
            chk("tt_end", int'(c), int'(ab == 2'b11));
            #1;
        end
        {a, b} = 2'b00;
        clk_en = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 1, 1, 0);
        step(0, 1, 1, 1, 0, 2, 2, 0);
        step(0, 1, 1, 1, 0, 3, 3, 1);
        step(0, 1, 1, 1, 0, 4, 3, 1);
        step(0, 1, 1, 1, 0, 5, 3, 1);
        step(0, 1, 0, 0, 0, 5, 3, 1);
        step(0, 1, 0, 0, 0, 5, 3, 1);
        step(0, 1, 0, 0, 0, 5, 3, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 1, 1, 0);
        step(0, 1, 1, 1, 0, 2, 2, 0);
        step(0, 1, 1, 1, 0, 3, 3, 1);
        step(0, 1, 1, 1, 0, 4, 3, 1);
        step(0, 1, 1, 1, 0, 5, 3, 1);
        step(0, 1, 1, 1, 0, 6, 3, 1);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 1, 1, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        count_pulses = 1'b1;
        step(0, 1, 1, 1, 1, 1, 1, 0);
        step(0, 0, 1, 0, 0, 1, 1, 0);
        step(0, 1, 1, 1, 1, 2, 2, 0);
        step(0, 0, 1, 0, 0, 2, 2, 0);
        step(0, 1, 1, 1, 1, 3, 3, 1);
        step(0, 0, 1, 0, 0, 3, 3, 1);
        step(0, 1, 1, 1, 1, 4, 3, 1);
        step(0, 0, 1, 0, 0, 4, 3, 1);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        count_pulses = 1'b0;
        chk("toggle_pulses", pulses, 4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
